// File: rtl/wb_dcache_controller_pkg.sv
// Shared types for the write-back data cache controller: the sequencing FSM
// state encoding and the default index width.
package wb_dcache_controller_pkg;

    localparam int DCACHE_IDX_BITS_DEFAULT = 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOOKUP,
        S_WR_HIT,
        S_VICTIM_SWAP,
        S_WRITEBACK,
        S_TO_VICTIM,
        S_ALLOCATE,
        S_FLUSH_RD,
        S_FLUSH_CHK,
        S_FLUSH_WB,
        S_FLUSH_DONE
    } type_dcache_ctrl_state_e;

    function automatic logic is_flush_state(input type_dcache_ctrl_state_e s);
        return (s == S_FLUSH_RD) || (s == S_FLUSH_CHK) ||
               (s == S_FLUSH_WB) || (s == S_FLUSH_DONE);
    endfunction

endpackage

// File: rtl/wb_dcache_controller.sv
// Sequencing FSM for the write-back data cache with victim cache: lookup,
// writeback, victim swap, line allocate and full-index flush walk.
module wb_dcache_controller
    import wb_dcache_controller_pkg::*;
#(
    parameter int DCACHE_IDX_BITS = DCACHE_IDX_BITS_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       lsummu2dcache_req_i,
    input  logic                       lsummu2dcache_wr_i,
    input  logic                       dcache_flush_i,
    input  logic                       cache_hit_i,
    input  logic                       cache_evict_req_i,
    input  logic                       dcache_valid_i,
    input  logic                       victim_hit_i,
    input  logic                       mem2dcache_ack_i,
    output logic                       dcache2lsummu_ack_o,
    output logic                       dcache_flush_ack_o,
    output logic                       cache_wr_o,
    output logic                       cache_line_wr_o,
    output logic                       cache_line_clean_o,
    output logic                       cache_wrb_req_o,
    output logic                       write_from_victim_o,
    output logic                       write_to_victim_o,
    output logic                       lsu_victim_mux_sel_o,
    output logic                       dcache_flush_o,
    output logic [DCACHE_IDX_BITS-1:0] evict_index_o,
    output logic                       dcache2mem_req_o,
    output logic                       dcache2mem_wr_o
);

    localparam logic [DCACHE_IDX_BITS-1:0] IDX_LAST = '1;

    type_dcache_ctrl_state_e     state_q, state_d;
    logic [DCACHE_IDX_BITS-1:0]  idx_q, idx_d;
    logic                        vhit_q, vhit_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vhit_d  = vhit_q;
        case (state_q)
            S_IDLE: begin
                if (dcache_flush_i) begin
                    state_d = S_FLUSH_RD;
                    idx_d   = '0;
                end else if (lsummu2dcache_req_i) begin
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                // Remember the victim hit so a dirty line can be written back before the swap.
                vhit_d = victim_hit_i;
                if (cache_hit_i) begin
                    state_d = lsummu2dcache_wr_i ? S_WR_HIT : S_IDLE;
                end else if (dcache_valid_i && cache_evict_req_i) begin
                    state_d = S_WRITEBACK;
                end else if (victim_hit_i) begin
                    state_d = S_VICTIM_SWAP;
                end else if (dcache_valid_i) begin
                    state_d = S_TO_VICTIM;
                end else begin
                    state_d = S_ALLOCATE;
                end
            end
            S_WR_HIT: state_d = S_IDLE;
            S_VICTIM_SWAP: state_d = lsummu2dcache_wr_i ? S_WR_HIT : S_IDLE;
            S_WRITEBACK: begin
                if (mem2dcache_ack_i) begin
                    state_d = vhit_q ? S_VICTIM_SWAP : S_TO_VICTIM;
                end
            end
            S_TO_VICTIM: state_d = S_ALLOCATE;
            S_ALLOCATE: begin
                if (mem2dcache_ack_i) begin
                    state_d = S_LOOKUP;
                end
            end
            S_FLUSH_RD: state_d = S_FLUSH_CHK;
            S_FLUSH_CHK, S_FLUSH_WB: begin
                if ((state_q == S_FLUSH_CHK && !(cache_evict_req_i && dcache_valid_i)) ||
                    (state_q == S_FLUSH_WB && mem2dcache_ack_i)) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_FLUSH_DONE;
                    end else begin
                        idx_d   = idx_q + DCACHE_IDX_BITS'(1);
                        state_d = S_FLUSH_RD;
                    end
                end else if (state_q == S_FLUSH_CHK) begin
                    state_d = S_FLUSH_WB;
                end
            end
            S_FLUSH_DONE: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            vhit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vhit_q  <= vhit_d;
        end
    end

    // Strobes are decoded from state so line/clean writes coincide with the memory ack.
    always_comb begin
        dcache2lsummu_ack_o  = 1'b0;
        dcache_flush_ack_o   = 1'b0;
        cache_wr_o           = 1'b0;
        cache_line_wr_o      = 1'b0;
        cache_line_clean_o   = 1'b0;
        cache_wrb_req_o      = 1'b0;
        write_from_victim_o  = 1'b0;
        write_to_victim_o    = 1'b0;
        lsu_victim_mux_sel_o = 1'b0;
        dcache2mem_req_o     = 1'b0;
        dcache2mem_wr_o      = 1'b0;
        case (state_q)
            S_LOOKUP: dcache2lsummu_ack_o = cache_hit_i && !lsummu2dcache_wr_i;
            S_WR_HIT: begin
                cache_wr_o          = 1'b1;
                dcache2lsummu_ack_o = 1'b1;
            end
            S_VICTIM_SWAP: begin
                write_from_victim_o = 1'b1;
                write_to_victim_o   = dcache_valid_i;
                if (!lsummu2dcache_wr_i) begin
                    lsu_victim_mux_sel_o = 1'b1;
                    dcache2lsummu_ack_o  = 1'b1;
                end
            end
            S_WRITEBACK: begin
                cache_wrb_req_o  = 1'b1;
                dcache2mem_req_o = 1'b1;
                dcache2mem_wr_o  = 1'b1;
            end
            S_TO_VICTIM: write_to_victim_o = 1'b1;
            S_ALLOCATE: begin
                dcache2mem_req_o = 1'b1;
                cache_line_wr_o  = mem2dcache_ack_i;
            end
            S_FLUSH_WB: begin
                cache_wrb_req_o    = 1'b1;
                dcache2mem_req_o   = 1'b1;
                dcache2mem_wr_o    = 1'b1;
                cache_line_clean_o = mem2dcache_ack_i;
            end
            S_FLUSH_DONE: dcache_flush_ack_o = 1'b1;
            default: ;
        endcase
    end

    assign dcache_flush_o = is_flush_state(state_q);
    assign evict_index_o  = idx_q;

endmodule

// File: tb/tb_wb_dcache_controller.sv
// Randomized bench for wb_dcache_controller against a transaction-level model
// of latency and datapath/memory event counts.
module tb_wb_dcache_controller;

    localparam int IDX  = 2;
    localparam int NIDX = 1 << IDX;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic lsummu2dcache_req_i = 1'b0, lsummu2dcache_wr_i = 1'b0, dcache_flush_i = 1'b0;
    logic cache_hit_i, cache_evict_req_i, dcache_valid_i, victim_hit_i;
    logic mem2dcache_ack_i = 1'b0;
    logic dcache2lsummu_ack_o, dcache_flush_ack_o, cache_wr_o, cache_line_wr_o;
    logic cache_line_clean_o, cache_wrb_req_o, write_from_victim_o, write_to_victim_o;
    logic lsu_victim_mux_sel_o, dcache_flush_o, dcache2mem_req_o, dcache2mem_wr_o;
    logic [IDX-1:0] evict_index_o;

    logic hit_s = 1'b0, vhit_s = 1'b0, valid_s = 1'b0, dirty_s = 1'b0;
    logic [NIDX-1:0] fvalid = '0, fdirty = '0;

    assign cache_hit_i       = hit_s;
    assign victim_hit_i      = vhit_s;
    assign dcache_valid_i    = dcache_flush_o ? fvalid[evict_index_o] : valid_s;
    assign cache_evict_req_i = dcache_flush_o ? fdirty[evict_index_o] : dirty_s;

    wb_dcache_controller #(.DCACHE_IDX_BITS(IDX)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsummu2dcache_req_i(lsummu2dcache_req_i), .lsummu2dcache_wr_i(lsummu2dcache_wr_i),
        .dcache_flush_i(dcache_flush_i), .cache_hit_i(cache_hit_i),
        .cache_evict_req_i(cache_evict_req_i), .dcache_valid_i(dcache_valid_i),
        .victim_hit_i(victim_hit_i), .mem2dcache_ack_i(mem2dcache_ack_i),
        .dcache2lsummu_ack_o(dcache2lsummu_ack_o), .dcache_flush_ack_o(dcache_flush_ack_o),
        .cache_wr_o(cache_wr_o), .cache_line_wr_o(cache_line_wr_o),
        .cache_line_clean_o(cache_line_clean_o), .cache_wrb_req_o(cache_wrb_req_o),
        .write_from_victim_o(write_from_victim_o), .write_to_victim_o(write_to_victim_o),
        .lsu_victim_mux_sel_o(lsu_victim_mux_sel_o), .dcache_flush_o(dcache_flush_o),
        .evict_index_o(evict_index_o), .dcache2mem_req_o(dcache2mem_req_o),
        .dcache2mem_wr_o(dcache2mem_wr_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cyc, cur_lat, mcnt;
    bit spur_en = 1'b0;
    bit pend_hit;
    int n_ack, n_fack, ack_cyc, fack_cyc, n_cwr, n_lwr, n_clean, n_wb, n_fill;
    int n_tov, n_from, n_mux, n_mreq, n_excl, n_bad, wb_cyc, fill_cyc;
    int wbq[$];

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int outs_vec();
        return int'({dcache2lsummu_ack_o, dcache_flush_ack_o, cache_wr_o, cache_line_wr_o,
                     cache_line_clean_o, cache_wrb_req_o, write_from_victim_o,
                     write_to_victim_o, lsu_victim_mux_sel_o, dcache_flush_o,
                     evict_index_o, dcache2mem_req_o, dcache2mem_wr_o});
    endfunction

    task automatic clear_obs();
        n_ack = 0; n_fack = 0; ack_cyc = -1; fack_cyc = -1; n_cwr = 0; n_lwr = 0;
        n_clean = 0; n_wb = 0; n_fill = 0; n_tov = 0; n_from = 0; n_mux = 0;
        n_mreq = 0; n_excl = 0; n_bad = 0; wb_cyc = -1; fill_cyc = -1;
        wbq.delete(); pend_hit = 1'b0;
    endtask

    // One clock: apply datapath effects of the last cycle, run the memory, then observe.
    task automatic tick();
        bit mack;
        @(negedge clk);
        if (pend_hit) hit_s = 1'b1;
        pend_hit = 1'b0;
        if (dcache2mem_req_o) begin
            mcnt++;
            mem2dcache_ack_i = (mcnt == cur_lat);
        end else begin
            mcnt = 0;
            mem2dcache_ack_i = spur_en && ($urandom_range(0, 3) == 0);
        end
        #1;
        cyc++;
        mack = dcache2mem_req_o && mem2dcache_ack_i;
        if (dcache2lsummu_ack_o) begin n_ack++; if (ack_cyc < 0) ack_cyc = cyc; end
        if (dcache_flush_ack_o) begin n_fack++; if (fack_cyc < 0) fack_cyc = cyc; end
        if (cache_wr_o) n_cwr++;
        if (cache_line_wr_o) begin n_lwr++; pend_hit = 1'b1; end
        if (cache_line_clean_o) begin n_clean++; fdirty[evict_index_o] = 1'b0; end
        if (write_from_victim_o) begin n_from++; pend_hit = 1'b1; end
        if (write_to_victim_o) n_tov++;
        if (lsu_victim_mux_sel_o) n_mux++;
        if (dcache2mem_req_o) n_mreq++;
        if (mack && dcache2mem_wr_o) begin
            n_wb++; wb_cyc = cyc;
            if (dcache_flush_o) wbq.push_back(int'(evict_index_o));
        end
        if (mack && !dcache2mem_wr_o) begin n_fill++; fill_cyc = cyc; end
        if (int'(cache_wr_o) + int'(cache_line_wr_o) + int'(cache_line_clean_o) +
            int'(write_from_victim_o) > 1) n_excl++;
        if (cache_line_wr_o && !(mack && !dcache2mem_wr_o)) n_bad++;
        if (cache_line_clean_o && !(mack && dcache2mem_wr_o && dcache_flush_o)) n_bad++;
    endtask

    // Request outcome derived from the lookup rules: cycles from the request cycle to ack.
    task automatic model(input bit wr, h, vh, v, d, input int L,
                         output int lat, nwb, nfill, ntov, nfrom, ncwr, nmux);
        lat = 1; nwb = 0; nfill = 0; ntov = 0; nfrom = 0; ncwr = 0; nmux = 0;
        if (!h) begin
            if (v && d) begin nwb = 1; lat += L; end
            if (vh) begin
                nfrom = 1; ntov = int'(v); lat += 1;
                if (!wr) nmux = 1;
            end else begin
                if (v) begin ntov = 1; lat += 1; end
                nfill = 1; lat += L + 1;
            end
        end
        if (wr) begin ncwr = 1; lat += 1; end
    endtask

    task automatic run_req(input string tag, input bit wr, h, vh, v, d, input int L);
        int lat, nwb, nfill, ntov, nfrom, ncwr, nmux;
        model(wr, h, vh, v, d, L, lat, nwb, nfill, ntov, nfrom, ncwr, nmux);
        clear_obs();
        hit_s = h; vhit_s = vh; valid_s = v; dirty_s = d; cur_lat = L;
        lsummu2dcache_wr_i = wr; lsummu2dcache_req_i = 1'b1; cyc = 0;
        while (n_ack == 0 && cyc < 300) tick();
        lsummu2dcache_req_i = 1'b0;
        tick();
        check({tag, ".ack_count"}, n_ack, 1);
        check({tag, ".latency"}, ack_cyc, lat);
        check({tag, ".writebacks"}, n_wb, nwb);
        check({tag, ".fills"}, n_fill, nfill);
        check({tag, ".line_wr"}, n_lwr, nfill);
        check({tag, ".mem_req_cycles"}, n_mreq, (nwb + nfill) * L);
        check({tag, ".to_victim"}, n_tov, ntov);
        check({tag, ".from_victim"}, n_from, nfrom);
        check({tag, ".cache_wr"}, n_cwr, ncwr);
        check({tag, ".mux_sel"}, n_mux, nmux);
        check({tag, ".exclusive"}, n_excl, 0);
        check({tag, ".strobe_align"}, n_bad, 0);
        if (nwb != 0 && nfill != 0) check({tag, ".wb_before_fill"}, int'(wb_cyc < fill_cyc), 1);
    endtask

    task automatic run_flush(input string tag, input logic [NIDX-1:0] vm, dm,
                             input bit with_req, input int L);
        int nd = 0;
        int expq[$];
        for (int i = 0; i < NIDX; i++) if (vm[i] && dm[i]) begin nd++; expq.push_back(i); end
        clear_obs();
        fvalid = vm; fdirty = dm; cur_lat = L;
        hit_s = 1'b1; valid_s = 1'b1; vhit_s = 1'b0; dirty_s = 1'b0;
        lsummu2dcache_wr_i = 1'b0; lsummu2dcache_req_i = with_req;
        dcache_flush_i = 1'b1; cyc = 0;
        while ((n_fack == 0 || (with_req && n_ack == 0)) && cyc < 400) begin
            tick();
            if (n_fack != 0) dcache_flush_i = 1'b0;
            if (n_ack != 0) lsummu2dcache_req_i = 1'b0;
        end
        dcache_flush_i = 1'b0; lsummu2dcache_req_i = 1'b0;
        tick();
        check({tag, ".flush_ack_count"}, n_fack, 1);
        check({tag, ".flush_ack_cycle"}, fack_cyc, 2 * NIDX + nd * L + 1);
        check({tag, ".writebacks"}, n_wb, nd);
        check({tag, ".cleans"}, n_clean, nd);
        check({tag, ".mem_req_cycles"}, n_mreq, nd * L);
        check({tag, ".fills"}, n_fill, 0);
        check({tag, ".wb_list_len"}, wbq.size(), nd);
        for (int i = 0; i < nd && i < wbq.size(); i++) check({tag, ".wb_index"}, wbq[i], expq[i]);
        check({tag, ".exclusive"}, n_excl, 0);
        check({tag, ".strobe_align"}, n_bad, 0);
        if (with_req) begin
            check({tag, ".req_ack_count"}, n_ack, 1);
            check({tag, ".req_after_flush"}, ack_cyc, fack_cyc + 2);
        end else begin
            check({tag, ".no_req_ack"}, n_ack, 0);
        end
    endtask

    task automatic run_reset_in_allocate();
        bit reached = 1'b0;
        clear_obs();
        hit_s = 1'b0; vhit_s = 1'b0; valid_s = 1'b0; dirty_s = 1'b0; cur_lat = 8;
        lsummu2dcache_wr_i = 1'b0; lsummu2dcache_req_i = 1'b1; cyc = 0;
        while (!reached && cyc < 50) begin
            tick();
            reached = dcache2mem_req_o && !dcache2mem_wr_o;
        end
        check("rst_alloc.reached", int'(reached), 1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_alloc.outputs", outs_vec(), 0);
        lsummu2dcache_req_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        run_req("rst_alloc.after", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    endtask

    initial begin
        clear_obs();
        cyc = 0; mcnt = 0; cur_lat = 1;
        repeat (3) @(negedge clk);
        #1;
        check("reset.outputs", outs_vec(), 0);
        rst_n = 1'b1;

        run_req("load_hit",      1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        run_req("store_hit",     1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1);
        run_req("dirty_miss",    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3);
        run_req("victim_store",  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2);
        run_req("victim_load",   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2);
        run_req("victim_dirty",  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2);
        run_req("clean_miss",    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        run_req("invalid_store", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        run_flush("flush_1_3", 4'b1011, 4'b1110, 1'b0, 2);
        run_flush("flush_req", 4'b0110, 4'b0010, 1'b1, 3);
        run_reset_in_allocate();

        spur_en = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if (t % 8 == 7) begin
                run_flush("rand_flush", NIDX'($urandom), NIDX'($urandom), 1'($urandom),
                          int'($urandom_range(1, 4)));
            end else begin
                run_req("rand_req", 1'($urandom), 1'($urandom), 1'($urandom),
                        1'($urandom), 1'($urandom), int'($urandom_range(1, 4)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
